// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, the receiver's state encoding, and the
// state encoding for the downstream FIFO handshake.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy flags.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nxt;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are derived from the next occupancy so all three update on the same edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

endmodule

// File: rtl/rx_fifo.sv
// Receiver-side byte buffer: four-phase req/ack slave feeding a FWFT FIFO,
// with a sticky overflow flag for bytes dropped while full.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       req,
  input  logic [DATA_W-1:0]          data,
  output logic                       ack,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  hs_state_t state;
  hs_state_t state_nxt;
  logic      capture;
  logic      drop;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= H_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    capture   = 1'b0;
    case (state)
      H_IDLE: begin
        if (req) begin
          capture   = 1'b1;
          state_nxt = H_ACK;
        end
      end
      H_ACK: begin
        ack = 1'b1;
        if (!req) state_nxt = H_IDLE;
      end
      default: state_nxt = H_IDLE;
    endcase
  end

  // A full FIFO still takes the byte if the host pops in the same cycle.
  assign drop = capture && full && !rd_en;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push    (capture),
    .wr_data (data),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: handshake, FIFO ordering, overflow and async reset.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       clr;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    req  = 1'b1;
    data = b;
    tick();
    req  = 1'b0;
    tick();
  endtask

  initial begin
    clr = 1'b0; req = 1'b0; data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    #22;
    chk("rst_ack", ack, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_data", rd_data, 0);
    clr = 1'b1;
    tick();

    // single byte
    req = 1'b1; data = 8'hA5;
    tick();
    chk("sb_ack_hi", ack, 1);
    chk("sb_count", count, 1);
    chk("sb_empty", empty, 0);
    chk("sb_rd_data", rd_data, 8'hA5);
    req = 1'b0;
    tick();
    chk("sb_ack_lo", ack, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("sb_pop_empty", empty, 1);
    chk("sb_pop_count", count, 0);

    // req held for 10 cycles
    req = 1'b1; data = 8'h3C;
    repeat (10) tick();
    chk("held_count", count, 1);
    chk("held_ack", ack, 1);
    chk("held_rd_data", rd_data, 8'h3C);
    req = 1'b0;
    tick();
    chk("held_ack_lo", ack, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("held_pop_count", count, 0);

    // fill and overflow
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    req = 1'b1; data = 8'hFF;
    tick();
    chk("ovf_ack_hi", ack, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", rd_data, 8'h00);
    req = 1'b0;
    tick();
    chk("ovf_ack_lo", ack, 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rd_data, 32'(i));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // push and pop together while empty: only the push happens
    req = 1'b1; data = 8'h77; rd_en = 1'b1;
    tick();
    chk("pp_empty_count", count, 1);
    chk("pp_empty_data", rd_data, 8'h77);
    req = 1'b0; rd_en = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pp_empty_drain", count, 0);

    // concurrent push/pop at occupancy 3 with pointer wrap
    for (int j = 0; j < 3; j++) send(8'(8'h40 + j));
    chk("cc_pre_count", count, 3);
    for (int k = 0; k < 40; k++) begin
      chk("cc_head", rd_data, 32'(8'(8'h40 + k)));
      req = 1'b1; data = 8'(8'h43 + k); rd_en = 1'b1;
      tick();
      chk("cc_count", count, 3);
      req = 1'b0; rd_en = 1'b0;
      tick();
    end
    for (int k = 40; k < 43; k++) begin
      chk("cc_tail", rd_data, 32'(8'(8'h40 + k)));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("cc_empty", empty, 1);

    // pop while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("ep_count", count, 0);
    chk("ep_empty", empty, 1);
    send(8'h5A);
    chk("ep_next_data", rd_data, 8'h5A);
    chk("ep_next_count", count, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // full with simultaneous push/pop, drop racing ovf_clr, then async reset
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    chk("f2_full", full, 1);
    req = 1'b1; data = 8'hEE; rd_en = 1'b1;
    tick();
    chk("f2_pp_count", count, 16);
    chk("f2_pp_ovf", overflow, 0);
    chk("f2_pp_head", rd_data, 8'h81);
    req = 1'b0; rd_en = 1'b0;
    tick();
    req = 1'b1; data = 8'hFF; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("f2_set_wins", overflow, 1);
    chk("f2_ack", ack, 1);
    #3;
    clr = 1'b0;
    #1;
    chk("ar_ack", ack, 0);
    chk("ar_count", count, 0);
    chk("ar_full", full, 0);
    chk("ar_empty", empty, 1);
    chk("ar_ovf", overflow, 0);
    req = 1'b0;
    tick();
    clr = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
